deadlock_watchdog_ctrl: RTL
===========================

DEADLOCK_WATCHDOG_CTRL -- requirements
Module: deadlock_watchdog_ctrl

Interface
REQ-001 SHALL have parameter N_MON, default 4, number of per-instance deadlock monitor block inputs.
REQ-002 SHALL have parameter TIMEOUT, default 16, threshold in cycles used when timeout_cfg is 0.
REQ-003 SHALL have parameter CNT_W, default 16, width of the blocked-cycle counter and timeout_cfg.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  1 = watchdog armed; 0 = forced to IDLE.
REQ-007 clear  input  1  one-cycle pulse; aborts detection and releases a latched deadlock.
REQ-008 mon_block  input  N_MON  per-monitor block flags, bit i from monitor i.
REQ-009 mon_idle  input  N_MON  per-instance idle flags; a block with idle set is ignored.
REQ-010 timeout_cfg  input  CNT_W  runtime threshold; 0 selects TIMEOUT.
REQ-011 deadlock  output  1  latched deadlock indication.
REQ-012 deadlock_idx  output  max(1,clog2(N_MON))  lowest index in block_mask when deadlock set.
REQ-013 block_mask  output  N_MON  accumulated OR of qualified blocks since entering SUSPECT.
REQ-014 blocked_cycles  output  CNT_W  consecutive qualified-block cycle count.
REQ-015 state  output  2  FSM state: 0 IDLE, 1 WATCH, 2 SUSPECT, 3 DEADLOCK.

Function
REQ-016 Qualified block vector qb = mon_block & ~mon_idle; "active" = |qb.
REQ-017 Effective threshold thr = (timeout_cfg==0 ? TIMEOUT : timeout_cfg), clamped to minimum 2, sampled into a register on WATCH->SUSPECT; timeout_cfg changes mid-SUSPECT have no effect.
REQ-018 IDLE: enable=1 -> WATCH next cycle; counter, mask held 0.
REQ-019 WATCH: active -> SUSPECT, blocked_cycles<=1, block_mask<=qb; else stay, counter 0, mask 0.
REQ-020 SUSPECT: active=0 -> WATCH, blocked_cycles<=0, block_mask<=0 (any single unblocked cycle resets detection).
REQ-021 SUSPECT: active=1 -> blocked_cycles<=blocked_cycles+1, block_mask<=block_mask|qb; if blocked_cycles+1 == thr -> DEADLOCK.
REQ-022 Counter saturates at 2^CNT_W-1; never wraps.
REQ-023 On SUSPECT->DEADLOCK, deadlock_idx<=lowest set bit of (block_mask|qb); deadlock<=1.
REQ-024 DEADLOCK: sticky; counter, mask, idx frozen; monitor inputs ignored.
REQ-025 clear=1 in any state: next state WATCH if enable=1 else IDLE; deadlock, counter, mask, idx cleared; clear beats every other transition.
REQ-026 enable=0 (clear=0) in any state: next state IDLE, same clears as REQ-025.
REQ-027 Deadlock asserts exactly thr rising edges after the first edge sampling a qualified block in WATCH, given uninterrupted activity.
REQ-028 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-029 reset_n=0 asynchronously forces state=IDLE, deadlock=0, deadlock_idx=0, block_mask=0, blocked_cycles=0, threshold register=TIMEOUT.
REQ-030 Deassertion of reset_n is synchronous to clock; first active transition is IDLE->WATCH if enable=1.
REQ-031 Reset mid-SUSPECT or mid-DEADLOCK discards all detection state.

Verification
REQ-032 enable=1, timeout_cfg=0, mon_block=4'b0100 held, mon_idle=0 -> state 1,2,..; deadlock=1 exactly 16 edges after first block sampled, deadlock_idx=2, block_mask=4'b0100.
REQ-033 timeout_cfg=5, mon_block=4'b1000 for 4 cycles, 0 for 1 cycle, then 4'b0010 for 5 cycles -> counter returns to 0 at gap; deadlock on 5th cycle of second burst, idx=1, mask=4'b0010.
REQ-034 mon_block=4'b1111, mon_idle=4'b1111 for 100 cycles -> state stays WATCH, deadlock=0.
REQ-035 Latched deadlock, mon_block dropped to 0 -> deadlock remains 1; clear pulse -> next cycle deadlock=0, state=WATCH, counter=0.
REQ-036 timeout_cfg=1, mon_block=4'b0001 -> clamped thr=2, deadlock after 2 edges; timeout_cfg=0xFFFF reload mid-SUSPECT does not change thr.
REQ-037 reset_n pulsed low asynchronously (between edges) during SUSPECT with blocked_cycles=7 -> outputs zero immediately, state=IDLE before next edge.

Source files
------------

// File: rtl/deadlock_watchdog_ctrl.sv
// Deadlock watchdog: watches per-instance block flags and latches a deadlock
// once some non-idle monitor has been blocked for thr consecutive cycles.
module deadlock_watchdog_ctrl #(
  parameter int N_MON   = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = (N_MON > 1) ? $clog2(N_MON) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [N_MON-1:0] mon_block,
  input  logic [N_MON-1:0] mon_idle,
  input  logic [CNT_W-1:0] timeout_cfg,
  output logic             deadlock,
  output logic [IDX_W-1:0] deadlock_idx,
  output logic [N_MON-1:0] block_mask,
  output logic [CNT_W-1:0] blocked_cycles,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WATCH    = 2'd1,
    SUSPECT  = 2'd2,
    DEADLOCK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] THR_DEFAULT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] THR_MIN     = CNT_W'(2);

  // A threshold of 0 or 1 would collide with the WATCH->SUSPECT count of 1.
  function automatic logic [CNT_W-1:0] clamp_thr(input logic [CNT_W-1:0] cfg);
    logic [CNT_W-1:0] t;
    t = (cfg == '0) ? THR_DEFAULT : cfg;
    if (t < THR_MIN) t = THR_MIN;
    return t;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_MON-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N_MON - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  state_t           state_q;
  logic [CNT_W-1:0] thr_q;
  logic [N_MON-1:0] qb;
  logic             active;
  logic [CNT_W-1:0] cnt_nxt;
  logic [N_MON-1:0] mask_nxt;

  assign qb       = mon_block & ~mon_idle;
  assign active   = |qb;
  assign cnt_nxt  = sat_inc(blocked_cycles);
  assign mask_nxt = block_mask | qb;
  assign state    = state_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      deadlock       <= 1'b0;
      deadlock_idx   <= '0;
      block_mask     <= '0;
      blocked_cycles <= '0;
      thr_q          <= THR_DEFAULT;
    end else if (clear || !enable) begin
      // clear outranks every other transition, including a pending deadlock
      state_q        <= enable ? WATCH : IDLE;
      deadlock       <= 1'b0;
      deadlock_idx   <= '0;
      block_mask     <= '0;
      blocked_cycles <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q        <= WATCH;
          block_mask     <= '0;
          blocked_cycles <= '0;
        end
        WATCH: begin
          if (active) begin
            state_q        <= SUSPECT;
            blocked_cycles <= CNT_W'(1);
            block_mask     <= qb;
            thr_q          <= clamp_thr(timeout_cfg);
          end else begin
            block_mask     <= '0;
            blocked_cycles <= '0;
          end
        end
        SUSPECT: begin
          if (!active) begin
            state_q        <= WATCH;
            block_mask     <= '0;
            blocked_cycles <= '0;
          end else begin
            blocked_cycles <= cnt_nxt;
            block_mask     <= mask_nxt;
            if (cnt_nxt == thr_q) begin
              state_q      <= DEADLOCK;
              deadlock     <= 1'b1;
              deadlock_idx <= lowest_idx(mask_nxt);
            end
          end
        end
        DEADLOCK: begin
          state_q <= DEADLOCK;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
